// File: rtl/debounce_evt_arb.sv
// debounce_evt_arb: serialises per-channel press/release pulses onto one valid/ready
// event port with round-robin arbitration and sticky per-channel overflow flags.
module debounce_evt_arb #(
    parameter  int N   = 4,
    localparam int CHW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk50m,
    input  logic           rst_n,
    input  logic [N-1:0]   sw_hi,
    input  logic [N-1:0]   sw_lo,
    output logic           evt_valid,
    input  logic           evt_ready,
    output logic [CHW-1:0] evt_ch,
    output logic           evt_press,
    output logic [N-1:0]   ovf,
    input  logic           ovf_clr
);
    typedef enum logic {S_IDLE, S_OUT} state_t;

    state_t         state;
    logic [N-1:0]   slot_v, slot_t;
    logic [CHW-1:0] ptr, gnt;
    logic           gnt_any, take;
    logic [N-1:0]   one, both, gmask, load, ovf_set;

    // Descending scan so the last hit is the first valid slot at or after ptr.
    always_comb begin
        gnt_any = 1'b0;
        gnt     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            automatic int idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (slot_v[idx]) begin
                gnt_any = 1'b1;
                gnt     = CHW'(idx);
            end
        end
        take    = gnt_any & ((state == S_IDLE) | evt_ready);
        gmask   = take ? N'(1) << gnt : '0;
        one     = sw_hi ^ sw_lo;
        both    = sw_hi & sw_lo;
        load    = one & (~slot_v | gmask);
        ovf_set = both | (one & slot_v & ~gmask);
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            slot_v    <= '0;
            slot_t    <= '0;
            ptr       <= '0;
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_press <= 1'b0;
            ovf       <= '0;
        end else begin
            slot_v <= load | (slot_v & ~gmask);
            slot_t <= (slot_t & ~load) | (sw_hi & load);
            ovf    <= ovf_set | (ovf & {N{~ovf_clr}});
            if (take) begin
                ptr       <= (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;
                evt_ch    <= gnt;
                evt_press <= slot_t[gnt];
            end
            case (state)
                S_IDLE: if (take) begin
                    state     <= S_OUT;
                    evt_valid <= 1'b1;
                end
                S_OUT: if (evt_ready && !gnt_any) begin
                    state     <= S_IDLE;
                    evt_valid <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    evt_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_debounce_evt_arb.sv
// tb_debounce_evt_arb: directed and random checks of debounce_evt_arb against a
// transaction-level model of pending slots, round-robin choice and overflow.
module tb_debounce_evt_arb;
    localparam int N = 4;

    logic       clk50m = 1'b0;
    logic       rst_n;
    logic [3:0] sw_hi, sw_lo;
    logic       evt_valid, evt_ready, evt_press, ovf_clr;
    logic [1:0] evt_ch;
    logic [3:0] ovf;

    debounce_evt_arb #(.N(N)) dut (
        .clk50m(clk50m), .rst_n(rst_n), .sw_hi(sw_hi), .sw_lo(sw_lo),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
        .evt_press(evt_press), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk50m = ~clk50m;

    int checks = 0, failures = 0;
    bit m_sv[N], m_st[N];
    int m_ptr, m_ch;
    bit m_ov, m_pr;
    bit [3:0] m_ovf;
    bit sb_en = 1'b0;
    bit q[N][$];

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int c = 0; c < N; c++) begin
            m_sv[c] = 1'b0;
            m_st[c] = 1'b0;
        end
        m_ptr = 0; m_ch = 0; m_ov = 1'b0; m_pr = 1'b0; m_ovf = '0;
    endtask

    // One clock of the abstract model: output advances if free, then new pulses land.
    task automatic model_step(bit [3:0] hi, bit [3:0] lo, bit rdy, bit clr);
        int g = -1;
        bit [3:0] set = '0;
        if (!m_ov || rdy)
            for (int k = 0; k < N; k++) begin
                int c = (m_ptr + k) % N;
                if (g < 0 && m_sv[c]) g = c;
            end
        if (g >= 0) begin
            m_ov = 1'b1; m_ch = g; m_pr = m_st[g]; m_sv[g] = 1'b0; m_ptr = (g + 1) % N;
        end else if (rdy) m_ov = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (hi[c] && lo[c]) set[c] = 1'b1;
            else if (hi[c] || lo[c]) begin
                if (m_sv[c]) set[c] = 1'b1;
                else begin
                    m_sv[c] = 1'b1;
                    m_st[c] = hi[c];
                    if (sb_en) q[c].push_back(hi[c]);
                end
            end
        end
        m_ovf = set | (clr ? 4'b0 : m_ovf);
    endtask

    always @(negedge clk50m) begin
        check("valid", 32'(evt_valid), 32'(m_ov));
        check("ovf", 32'(ovf), 32'(m_ovf));
        if (m_ov) begin
            check("ch", 32'(evt_ch), 32'(m_ch));
            check("press", 32'(evt_press), 32'(m_pr));
        end
    end

    task automatic cyc(bit [3:0] hi, bit [3:0] lo, bit rdy, bit clr);
        bit e;
        sw_hi = hi; sw_lo = lo; evt_ready = rdy; ovf_clr = clr;
        #1;
        if (sb_en && evt_valid && evt_ready) begin
            if (q[evt_ch].size() == 0) check("sb_unexpected", 32'(evt_ch), 32'hFF);
            else begin
                e = q[evt_ch].pop_front();
                check("sb_order", 32'(evt_press), 32'(e));
            end
        end
        @(posedge clk50m);
        if (!rst_n) m_reset();
        else model_step(hi, lo, rdy, clr);
        @(negedge clk50m);
        sw_hi = '0; sw_lo = '0; ovf_clr = 1'b0;
    endtask

    task automatic lit(logic v, logic [1:0] ch, logic pr);
        check("lit_valid", 32'(evt_valid), 32'(v));
        if (v) begin
            check("lit_ch", 32'(evt_ch), 32'(ch));
            check("lit_press", 32'(evt_press), 32'(pr));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(0, 0, 1, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int last[N];
        bit [3:0] hi, lo;
        int r;
        m_reset();
        rst_n = 1'b0; sw_hi = '0; sw_lo = '0; evt_ready = 1'b1; ovf_clr = 1'b0;
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        lit(0, 0, 0);
        check("rst_ch", 32'(evt_ch), 0);
        check("rst_press", 32'(evt_press), 0);
        check("rst_ovf", 32'(ovf), 0);
        rst_n = 1'b1;
        // T1 single press, one cycle of valid
        cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
        cyc(4'b0100, 0, 1, 0); lit(0, 0, 0);
        cyc(0, 0, 1, 0);       lit(1, 2, 1);
        cyc(0, 0, 1, 0);       lit(0, 0, 0);
        check("t1_ovf", 32'(ovf), 0);
        // T2 simultaneous burst, ptr from 0, wrap back to 0
        do_reset();
        cyc(4'b1001, 4'b0010, 1, 0); lit(0, 0, 0);
        cyc(0, 0, 1, 0); lit(1, 0, 1);
        cyc(0, 0, 1, 0); lit(1, 1, 0);
        cyc(0, 0, 1, 0); lit(1, 3, 1);
        cyc(4'b0011, 0, 1, 0); lit(0, 0, 0);
        cyc(0, 0, 1, 0); lit(1, 0, 1);
        cyc(0, 0, 1, 0); lit(1, 1, 1);
        cyc(0, 0, 1, 0); lit(0, 0, 0);
        // T3 stalled output, slot fills, third pulse overflows
        cyc(4'b0010, 0, 0, 0); lit(0, 0, 0);
        cyc(0, 0, 0, 0); lit(1, 1, 1);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        cyc(0, 4'b0010, 0, 0); lit(1, 1, 1);
        cyc(4'b0010, 0, 0, 0); lit(1, 1, 1);
        check("t3_ovf", 32'(ovf), 32'h2);
        cyc(0, 0, 1, 0); lit(1, 1, 0);
        cyc(0, 0, 1, 0); lit(0, 0, 0);
        check("t3_ovf_sticky", 32'(ovf), 32'h2);
        // T4 protocol error, clear, set-beats-clear
        cyc(0, 0, 1, 1); check("t4_clr0", 32'(ovf), 0);
        cyc(4'b0100, 4'b0100, 1, 0); check("t4_err", 32'(ovf), 32'h4); lit(0, 0, 0);
        cyc(0, 0, 1, 0); lit(0, 0, 0);
        cyc(0, 0, 1, 1); check("t4_clr", 32'(ovf), 0);
        cyc(4'b0001, 4'b0001, 1, 1); check("t4_prio", 32'(ovf), 32'h1);
        cyc(0, 0, 1, 1);
        // T5 long hold, then async reset mid-hold
        cyc(4'b1000, 0, 0, 0);
        cyc(0, 0, 0, 0); lit(1, 3, 1);
        cyc(4'b0100, 4'b0100, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0);
            lit(1, 3, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(evt_valid), 0);
        check("t5_async_ovf", 32'(ovf), 0);
        m_reset();
        @(negedge clk50m);
        cyc(0, 0, 1, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
        lit(0, 0, 0);
        // T6 random traffic with scoreboard
        sb_en = 1'b1;
        for (int c = 0; c < N; c++) last[c] = -10;
        for (int t = 0; t < 400; t++) begin
            hi = '0; lo = '0;
            for (int c = 0; c < N; c++)
                if (t - last[c] >= 2 && $urandom_range(3) == 0) begin
                    last[c] = t;
                    r = int'($urandom_range(7));
                    if (r == 0) begin hi[c] = 1'b1; lo[c] = 1'b1; end
                    else if (r < 4) hi[c] = 1'b1;
                    else lo[c] = 1'b1;
                end
            cyc(hi, lo, $urandom_range(2) != 0, $urandom_range(49) == 0);
        end
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0);
        for (int c = 0; c < N; c++) check("sb_left", 32'(q[c].size()), 0);
        sb_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
